// File: rtl/sdram_arb_pkg.sv
// Shared state encoding, address padding and slot register layout for the SDRAM slot arbiter.
// No logic, so no latency or backpressure of its own.
package sdram_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int         MEM_ADDR_W = 25;
  localparam logic [2:0] ADDR_PAD   = 3'b000;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  we;
    logic [7:0]            din;
    logic                  oe_a;
    logic                  oe_b;
    logic                  dq_drive;
  } slot_t;

endpackage

// File: rtl/sdram_arb_fifo.sv
// Loader write buffer of {addr,data}; head visible combinationally, push/pop take effect at the clock edge.
// Push while full is dropped and sets the sticky overflow, unless a pop frees the slot in the same cycle.
module sdram_arb_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 22
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        push_addr,
  input  logic [7:0]               push_data,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [7:0]               head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  logic [ADDR_W+7:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign {head_addr, head_data} = mem[rd_ptr];

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= {push_addr, push_data};
  end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// Shares the SDRAM controller port between game loader and NES core; mem_* and dq_drive update only when ce_phase==SLOT_PHASE.
// Loader bytes queue in sdram_arb_fifo (sticky ld_overflow on drop); SDRAM_ARB_STATS_EN adds saturating slot counters.
module sdram_slot_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] SLOT_PHASE = 2'd3,
  parameter int         ADDR_W     = 22
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            ce_phase,
  input  logic                  load_done,
  input  logic                  ld_valid,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [7:0]            ld_data,
  input  logic [ADDR_W-1:0]     nes_addr,
  input  logic                  nes_rd_cpu,
  input  logic                  nes_rd_ppu,
  input  logic                  nes_wr,
  input  logic [7:0]            nes_dout,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_din,
  output logic                  mem_oe_a,
  output logic                  mem_oe_b,
  output logic                  dq_drive,
  output logic                  nes_owner,
`ifdef SDRAM_ARB_STATS_EN
  output logic [15:0]           stat_ld_writes,
  output logic [15:0]           stat_nes_slots,
`endif
  output logic                  ld_overflow
);

  logic [1:0]                  state;
  logic [1:0]                  state_nxt;
  slot_t                       slot_q;
  slot_t                       slot_nxt;
  logic                        boundary;
  logic                        fifo_push;
  logic                        fifo_pop;
  logic [ADDR_W-1:0]           head_addr;
  logic [7:0]                  head_data;
  logic                        fifo_full_unused;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign boundary  = (ce_phase == SLOT_PHASE);
  assign fifo_push = ld_valid && (state != ST_RUN);
  assign fifo_pop  = boundary && (state == ST_LOAD) && !fifo_empty;

  sdram_arb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .ADDR_W(ADDR_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .push_addr(ld_addr),
    .push_data(ld_data),
    .head_addr(head_addr),
    .head_data(head_data),
    .full     (fifo_full_unused),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (ld_overflow)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Leaving LOAD waits for an empty FIFO, so every buffered byte drains first.
  always_comb begin
    state_nxt = state;
    if (boundary) begin
      case (state)
        ST_IDLE: state_nxt = load_done ? ST_RUN : ST_LOAD;
        ST_LOAD: if (load_done && fifo_count == '0) state_nxt = ST_RUN;
        ST_RUN:  if (!load_done) state_nxt = ST_LOAD;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // IDLE and the RUN->LOAD switching slot issue nothing.
  always_comb begin
    slot_nxt = '0;
    case (state)
      ST_LOAD: begin
        if (!fifo_empty) begin
          slot_nxt.addr     = MEM_ADDR_W'({ADDR_PAD, head_addr});
          slot_nxt.din      = head_data;
          slot_nxt.we       = 1'b1;
          slot_nxt.dq_drive = 1'b1;
        end
      end
      ST_RUN: begin
        if (load_done) begin
          slot_nxt.addr     = MEM_ADDR_W'({ADDR_PAD, nes_addr});
          slot_nxt.din      = nes_dout;
          slot_nxt.we       = nes_wr;
          slot_nxt.oe_a     = nes_rd_cpu;
          slot_nxt.oe_b     = nes_rd_ppu;
          slot_nxt.dq_drive = nes_wr;
        end
      end
      default: slot_nxt = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         slot_q <= '0;
    else if (boundary) slot_q <= slot_nxt;
  end

  assign mem_addr  = slot_q.addr;
  assign mem_we    = slot_q.we;
  assign mem_din   = slot_q.din;
  assign mem_oe_a  = slot_q.oe_a;
  assign mem_oe_b  = slot_q.oe_b;
  assign dq_drive  = slot_q.dq_drive;
  assign nes_owner = (state == ST_RUN);

`ifdef SDRAM_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_ld_writes <= '0;
      stat_nes_slots <= '0;
    end else begin
      if (fifo_pop && stat_ld_writes != 16'hFFFF)
        stat_ld_writes <= stat_ld_writes + 16'd1;
      if (boundary && state == ST_RUN && load_done && (nes_wr || nes_rd_cpu || nes_rd_ppu)
          && stat_nes_slots != 16'hFFFF)
        stat_nes_slots <= stat_nes_slots + 16'd1;
    end
  end
`endif

endmodule
